// File: rtl/const_div_pkg.sv
// const_div_pkg: shared types and sizing helpers for the constant divider.
// Optional macro CONST_DIV_UNROLL2_EN selects two steps per cycle in the top.
package const_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int res_w(input int divisor);
    return $clog2(divisor);
  endfunction

  function automatic int nsteps(input int dw, input int cw);
    return (dw + cw - 1) / cw;
  endfunction

  // Dividend padded to whole cycles of upc steps each.
  function automatic int pad_w(input int ns, input int cw, input int upc);
    return ((ns + upc - 1) / upc) * upc * cw;
  endfunction

endpackage

// File: rtl/const_div_step.sv
// const_div_step: one quotient/residue digit step, acc={res_i,chunk_i}.
// Ports: res_i, chunk_i in; q_o = acc/DIVISOR, res_o = acc%DIVISOR out.
module const_div_step #(
  parameter int DIVISOR = 47,
  parameter int CHUNK_W = 3,
  parameter int RES_W   = 6
) (
  input  logic [RES_W-1:0]   res_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic [CHUNK_W-1:0] q_o,
  output logic [RES_W-1:0]   res_o
);

  localparam int AW = RES_W + CHUNK_W;

  logic [AW-1:0] acc;

  // res_i < DIVISOR bounds acc below DIVISOR<<CHUNK_W, so a
  // CHUNK_W-deep restoring subtract of shifted constants is exact.
  always_comb begin
    acc = {res_i, chunk_i};
    q_o = '0;
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (acc >= (AW'(DIVISOR) << i)) begin
        acc    = acc - (AW'(DIVISOR) << i);
        q_o[i] = 1'b1;
      end
    end
    res_o = acc[RES_W-1:0];
  end

endmodule

// File: rtl/const_div_seq.sv
// const_div_seq: digit-serial divide by constant with valid/ready handshakes.
// Ports: in_valid/in_ready/in_dividend, out_valid/out_ready/out_quot/out_rem, busy.
// Macro CONST_DIV_UNROLL2_EN: two cascaded steps per cycle.
module const_div_seq
  import const_div_pkg::*;
#(
  parameter int DIVIDEND_W = 36,
  parameter int DIVISOR    = 47,
  parameter int CHUNK_W    = 3,
  localparam int RES_W     = res_w(DIVISOR),
  localparam int NSTEPS    = nsteps(DIVIDEND_W, CHUNK_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quot,
  output logic [RES_W-1:0]      out_rem,
  output logic                  busy
);

`ifdef CONST_DIV_UNROLL2_EN
  localparam int UPC = 2;
`else
  localparam int UPC = 1;
`endif
  localparam int SW    = UPC * CHUNK_W;
  localparam int NCYC  = (NSTEPS + UPC - 1) / UPC;
  localparam int PAD_W = pad_w(NSTEPS, CHUNK_W, UPC);
  localparam int CNT_W = $clog2(NCYC + 1);

  state_e                state_q, state_d;
  logic [PAD_W-1:0]      sh_q, sh_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [CHUNK_W-1:0]    ch0, q0;
  logic [RES_W-1:0]      r0;
  logic [SW-1:0]         qdig;
  logic [RES_W-1:0]      res_nxt;

  assign ch0 = sh_q[PAD_W-1 -: CHUNK_W];

  const_div_step #(
    .DIVISOR(DIVISOR),
    .CHUNK_W(CHUNK_W),
    .RES_W  (RES_W)
  ) u_step0 (
    .res_i  (res_q),
    .chunk_i(ch0),
    .q_o    (q0),
    .res_o  (r0)
  );

`ifdef CONST_DIV_UNROLL2_EN
  logic [CHUNK_W-1:0] ch1, q1;
  logic [RES_W-1:0]   r1;

  assign ch1 = sh_q[PAD_W-CHUNK_W-1 -: CHUNK_W];

  const_div_step #(
    .DIVISOR(DIVISOR),
    .CHUNK_W(CHUNK_W),
    .RES_W  (RES_W)
  ) u_step1 (
    .res_i  (r0),
    .chunk_i(ch1),
    .q_o    (q1),
    .res_o  (r1)
  );

  assign qdig    = {q0, q1};
  assign res_nxt = r1;
`else
  assign qdig    = q0;
  assign res_nxt = r0;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    quot_d  = quot_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = PAD_W'(in_dividend);
          quot_d  = '0;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d   = {sh_q[PAD_W-SW-1:0], {SW{1'b0}}};
        // Padded MSB digits are zero, so truncating loses nothing.
        quot_d = {quot_q[DIVIDEND_W-SW-1:0], qdig};
        res_d  = res_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCYC - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      quot_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      quot_q  <= quot_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  // Mask so a partial result is never visible on the outputs.
  assign out_quot  = out_valid ? quot_q : '0;
  assign out_rem   = out_valid ? res_q : '0;

endmodule

// File: tb/tb_const_div_seq.sv
// tb_const_div_seq: scoreboard bench for const_div_seq (36-bit, /47, 3-bit chunks).
// Driver pushes expected results; a negedge monitor pops on each handshake.
module tb_const_div_seq;

  localparam int DW = 36;
  localparam int RW = 6;
`ifdef CONST_DIV_UNROLL2_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 12;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dividend = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_quot;
  logic [RW-1:0] out_rem;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] q;
    logic [RW-1:0] r;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ov_prev = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  const_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dividend(in_dividend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quot   (out_quot),
    .out_rem    (out_rem),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready) chk("in_ready_only_idle", {62'd0, busy, out_valid}, 64'd0);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(LAT));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("quot", 64'(out_quot), 64'(mon_e.q));
          chk("rem", 64'(out_rem), 64'(mon_e.r));
        end
      end
    end
    ov_prev = out_valid;
  end

  // Called at a negedge; returns at the negedge after acceptance,
  // leaving in_valid high so the next call is back-to-back.
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] q,
                      input logic [RW-1:0] r);
    exp_t e;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_dividend = d;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    e.q = q;
    e.r = r;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_quot"}, 64'(out_quot), 64'd0);
    chk({tag, "_rem"}, 64'(out_rem), 64'd0);
  endtask

  initial begin
    logic [63:0]   r64;
    logic [DW-1:0] d;
    int            n;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    send(36'd1000000, 36'd21276, 6'd28);
    send(36'hF_FFFF_FFFF, 36'd1462116526, 6'd13);
    send(36'd0, 36'd0, 6'd0);
    send(36'd47, 36'd1, 6'd0);
    send(36'd4700, 36'd100, 6'd0);
    drain();

    out_ready = 1'b0;
    send(36'd46, 36'd0, 6'd46);
    in_dividend = 36'd999;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_quot", 64'(out_quot), 64'd0);
      chk("hold_rem", 64'(out_rem), 64'd46);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    drain();

    send(36'd123456, 36'd2626, 6'd34);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    chk_reset_vals("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    send(36'd94, 36'd2, 6'd0);
    drain();

    for (int i = 0; i < 150; i++) begin
      r64 = {$urandom, $urandom};
      d = r64[DW-1:0];
      send(d, d / 47, RW'(d % 47));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
